// File: rtl/sdp_rdma_unpack_gen_if.sv
// -----------------------------------------------------------------------------
// sdp_rdma_unpack_gen_if
// Handshake bundle for the SDP read-DMA unpacker.
//   inp_pvld/inp_prdy/inp_data/inp_end : DMA return beats (atoms + atom mask)
//   out_pvld/out_prdy/out_data/out_end : packed beats (atoms + thermometer mask)
//   err_ovf                            : sticky overflow / malformed-mask flag
// Modports:
//   master : the side that produces input beats and consumes output beats
//   slave  : the unpacker itself
// -----------------------------------------------------------------------------
interface sdp_rdma_unpack_gen_if #(
   parameter int ATOM_W    = 256,
   parameter int IN_ATOMS  = 1,
   parameter int OUT_ATOMS = 4
);
   logic                                  inp_pvld;
   logic                                  inp_prdy;
   logic [IN_ATOMS*ATOM_W+IN_ATOMS-1:0]   inp_data;
   logic                                  inp_end;
   logic                                  out_pvld;
   logic                                  out_prdy;
   logic [OUT_ATOMS*ATOM_W+OUT_ATOMS-1:0] out_data;
   logic                                  out_end;
   logic                                  err_ovf;

   modport master (
      output inp_pvld, inp_data, inp_end, out_prdy,
      input  inp_prdy, out_pvld, out_data, out_end, err_ovf
   );

   modport slave (
      input  inp_pvld, inp_data, inp_end, out_prdy,
      output inp_prdy, out_pvld, out_data, out_end, err_ovf
   );
endinterface

// File: rtl/sdp_rdma_unpack_gen.sv
// -----------------------------------------------------------------------------
// sdp_rdma_unpack_gen
// Concatenates DMA return beats of 0..IN_ATOMS atoms into output beats of
// OUT_ATOMS atoms. A beat is emitted when the pack fills or the packet ends;
// the output carries a thermometer mask of valid atoms and an end flag.
// Ports:
//   autosa_core_clk  : clock, all state on rising edge
//   autosa_core_rstn : asynchronous active-low reset
//   io_bus           : sdp_rdma_unpack_gen_if.slave (input/output handshakes,
//                      sticky err_ovf)
// Build option:
//   AUTOSA_SDP_RDMA_UNPACK_ERR_EN : enables the sticky err_ovf check
//                                   (overflow or non-thermometer input mask).
//                                   Undefined -> err_ovf tied to 0.
// -----------------------------------------------------------------------------
module sdp_rdma_unpack_gen #(
   parameter int ATOM_W    = 256,
   parameter int IN_ATOMS  = 1,
   parameter int OUT_ATOMS = 4
) (
   input  logic                  autosa_core_clk,
   input  logic                  autosa_core_rstn,
   sdp_rdma_unpack_gen_if.slave  io_bus
);
   localparam int CNT_W = $clog2(OUT_ATOMS + 1);
   // cnt + size can reach OUT_ATOMS-1+IN_ATOMS, so one extra bit is needed
   localparam int SUM_W = CNT_W + 1;
   localparam int SZ_W  = $clog2(IN_ATOMS + 1);

   function automatic logic [SZ_W-1:0] f_popcnt(input logic [IN_ATOMS-1:0] m);
      logic [SZ_W-1:0] v;
      v = '0;
      for (int i = 0; i < IN_ATOMS; i++) v = v + SZ_W'(m[i]);
      return v;
   endfunction

   // Bits above OUT_ATOMS fall off, which gives the min(n, OUT_ATOMS) clamp.
   function automatic logic [OUT_ATOMS-1:0] f_therm_out(input logic [SUM_W-1:0] n);
      logic [OUT_ATOMS-1:0] t;
      for (int i = 0; i < OUT_ATOMS; i++) t[i] = (SUM_W'(i) < n);
      return t;
   endfunction

   logic [IN_ATOMS-1:0]  w_mask;
   logic [SZ_W-1:0]      w_size;
   logic [SUM_W-1:0]     w_cnt_nxt;
   logic                 w_is_last;
   logic                 w_inp_prdy;
   logic                 w_accept;
   logic [ATOM_W-1:0]    w_pack_nxt [OUT_ATOMS];
   logic [OUT_ATOMS*ATOM_W+OUT_ATOMS-1:0] w_out_data;

   logic [CNT_W-1:0]     r_cnt;
   logic                 r_out_pvld;
   logic                 r_out_end;
   logic [OUT_ATOMS-1:0] r_mask;
   logic [ATOM_W-1:0]    r_pack [OUT_ATOMS];

   assign w_mask     = io_bus.inp_data[IN_ATOMS*ATOM_W +: IN_ATOMS];
   assign w_size     = f_popcnt(w_mask);
   assign w_cnt_nxt  = SUM_W'(r_cnt) + SUM_W'(w_size);
   assign w_is_last  = (w_cnt_nxt >= SUM_W'(OUT_ATOMS)) | io_bus.inp_end;
   assign w_inp_prdy = !r_out_pvld | io_bus.out_prdy;
   assign w_accept   = io_bus.inp_pvld & w_inp_prdy;

   // Atoms always come from lanes 0..size-1; lanes past OUT_ATOMS are dropped.
   // Starting a fresh pack clears every lane so unwritten lanes read 0.
   always_comb begin
      for (int j = 0; j < OUT_ATOMS; j++) begin
         w_pack_nxt[j] = (r_cnt == '0) ? '0 : r_pack[j];
         for (int k = 0; k < IN_ATOMS; k++) begin
            if (k < int'(w_size) && j == int'(r_cnt) + k)
               w_pack_nxt[j] = io_bus.inp_data[k*ATOM_W +: ATOM_W];
         end
      end
   end

   // Pack data is not reset; it is fully rewritten before it is ever emitted.
   always_ff @(posedge autosa_core_clk) begin
      if (w_accept) begin
         for (int j = 0; j < OUT_ATOMS; j++) r_pack[j] <= w_pack_nxt[j];
      end
   end

   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
         r_cnt      <= '0;
         r_out_pvld <= 1'b0;
         r_out_end  <= 1'b0;
         r_mask     <= '0;
      end else begin
         if (w_inp_prdy) r_out_pvld <= io_bus.inp_pvld & w_is_last;
         if (w_accept) begin
            if (w_is_last) begin
               r_cnt     <= '0;
               r_mask    <= f_therm_out(w_cnt_nxt);
               r_out_end <= io_bus.inp_end;
            end else begin
               r_cnt     <= w_cnt_nxt[CNT_W-1:0];
            end
         end
      end
   end

`ifdef AUTOSA_SDP_RDMA_UNPACK_ERR_EN
   function automatic logic [IN_ATOMS-1:0] f_therm_in(input logic [SZ_W-1:0] n);
      logic [IN_ATOMS-1:0] t;
      for (int i = 0; i < IN_ATOMS; i++) t[i] = (SZ_W'(i) < n);
      return t;
   endfunction

   logic r_err_ovf;
   always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn)
         r_err_ovf <= 1'b0;
      else if (w_accept && ((w_cnt_nxt > SUM_W'(OUT_ATOMS)) || (w_mask != f_therm_in(w_size))))
         r_err_ovf <= 1'b1;
   end
   assign io_bus.err_ovf = r_err_ovf;
`else
   assign io_bus.err_ovf = 1'b0;
`endif

   always_comb begin
      w_out_data = '0;
      for (int j = 0; j < OUT_ATOMS; j++) w_out_data[j*ATOM_W +: ATOM_W] = r_pack[j];
      w_out_data[OUT_ATOMS*ATOM_W +: OUT_ATOMS] = r_mask;
   end

   assign io_bus.inp_prdy = w_inp_prdy;
   assign io_bus.out_pvld = r_out_pvld;
   assign io_bus.out_end  = r_out_end;
   assign io_bus.out_data = w_out_data;
endmodule

// File: tb/tb_sdp_rdma_unpack_gen.sv
// -----------------------------------------------------------------------------
// tb_sdp_rdma_unpack_gen
// Directed bench: unit A uses the defaults (1 -> 4 atoms of 256 bits), unit B
// uses IN_ATOMS=2, OUT_ATOMS=3 with 8-bit atoms for the overflow cases.
// -----------------------------------------------------------------------------
module tb_sdp_rdma_unpack_gen;
   logic autosa_core_clk  = 1'b0;
   logic autosa_core_rstn = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;

`ifdef AUTOSA_SDP_RDMA_UNPACK_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   always #5 autosa_core_clk = ~autosa_core_clk;

   sdp_rdma_unpack_gen_if #(.ATOM_W(256), .IN_ATOMS(1), .OUT_ATOMS(4)) ifa ();
   sdp_rdma_unpack_gen_if #(.ATOM_W(8),   .IN_ATOMS(2), .OUT_ATOMS(3)) ifb ();

   sdp_rdma_unpack_gen #(.ATOM_W(256), .IN_ATOMS(1), .OUT_ATOMS(4)) u_dut_a (
      .autosa_core_clk  (autosa_core_clk),
      .autosa_core_rstn (autosa_core_rstn),
      .io_bus           (ifa.slave)
   );

   sdp_rdma_unpack_gen #(.ATOM_W(8), .IN_ATOMS(2), .OUT_ATOMS(3)) u_dut_b (
      .autosa_core_clk  (autosa_core_clk),
      .autosa_core_rstn (autosa_core_rstn),
      .io_bus           (ifb.slave)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge autosa_core_clk);
      #1;
   endtask

   function automatic logic [255:0] a_lane(input int j);
      return ifa.out_data[j*256 +: 256];
   endfunction

   function automatic logic [255:0] a_rep(input logic [7:0] b);
      return {32{b}};
   endfunction

   function automatic logic [7:0] b_lane(input int j);
      return ifb.out_data[j*8 +: 8];
   endfunction

   task automatic a_beat(input logic [7:0] b, input logic m, input logic e);
      ifa.inp_pvld = 1'b1;
      ifa.inp_data = {m, {32{b}}};
      ifa.inp_end  = e;
      tick();
   endtask

   task automatic a_idle();
      ifa.inp_pvld = 1'b0;
      ifa.inp_end  = 1'b0;
   endtask

   task automatic b_beat(input logic [1:0] m, input logic [7:0] l1, input logic [7:0] l0,
                         input logic e);
      ifb.inp_pvld = 1'b1;
      ifb.inp_data = {m, l1, l0};
      ifb.inp_end  = e;
      tick();
   endtask

   task automatic b_idle();
      ifb.inp_pvld = 1'b0;
      ifb.inp_end  = 1'b0;
   endtask

   initial begin
      ifa.inp_pvld = 1'b0; ifa.inp_data = '0; ifa.inp_end = 1'b0; ifa.out_prdy = 1'b1;
      ifb.inp_pvld = 1'b0; ifb.inp_data = '0; ifb.inp_end = 1'b0; ifb.out_prdy = 1'b1;
      repeat (3) @(posedge autosa_core_clk);
      #1;
      chk("rst_pvld", ifa.out_pvld, 0);
      chk("rst_end",  ifa.out_end, 0);
      chk("rst_mask", ifa.out_data[1024 +: 4], 0);
      chk("rst_err",  ifa.err_ovf, 0);
      autosa_core_rstn = 1'b1;
      tick();
      chk("rst_prdy", ifa.inp_prdy, 1);

      // four full beats -> one full output beat
      a_beat(8'h11, 1'b1, 1'b0);
      a_beat(8'h22, 1'b1, 1'b0);
      a_beat(8'h33, 1'b1, 1'b0);
      chk("full_pvld_early", ifa.out_pvld, 0);
      a_beat(8'h44, 1'b1, 1'b0);
      a_idle();
      chk("full_pvld", ifa.out_pvld, 1);
      chk("full_l0", a_lane(0), a_rep(8'h11));
      chk("full_l1", a_lane(1), a_rep(8'h22));
      chk("full_l2", a_lane(2), a_rep(8'h33));
      chk("full_l3", a_lane(3), a_rep(8'h44));
      chk("full_mask", ifa.out_data[1024 +: 4], 4'hf);
      chk("full_end", ifa.out_end, 0);
      tick();
      chk("full_drain", ifa.out_pvld, 0);

      // early end after two beats
      a_beat(8'haa, 1'b1, 1'b0);
      a_beat(8'hbb, 1'b1, 1'b1);
      a_idle();
      chk("early_pvld", ifa.out_pvld, 1);
      chk("early_mask", ifa.out_data[1024 +: 4], 4'h3);
      chk("early_end", ifa.out_end, 1);
      chk("early_l0", a_lane(0), a_rep(8'haa));
      chk("early_l1", a_lane(1), a_rep(8'hbb));
      chk("early_l2", a_lane(2), 0);
      chk("early_l3", a_lane(3), 0);
      tick();

      // backpressure: output held, then consume with a closing input
      ifa.out_prdy = 1'b0;
      a_beat(8'h11, 1'b1, 1'b0);
      a_beat(8'h22, 1'b1, 1'b0);
      a_beat(8'h33, 1'b1, 1'b0);
      a_beat(8'h44, 1'b1, 1'b0);
      ifa.inp_pvld = 1'b1;
      ifa.inp_data = {1'b1, {32{8'h55}}};
      ifa.inp_end  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_prdy", ifa.inp_prdy, 0);
         chk("bp_pvld", ifa.out_pvld, 1);
         chk("bp_l0", a_lane(0), a_rep(8'h11));
         chk("bp_l3", a_lane(3), a_rep(8'h44));
      end
      ifa.out_prdy = 1'b1;
      #1;
      chk("bp_prdy_comb", ifa.inp_prdy, 1);
      tick();
      a_idle();
      chk("bp_next_pvld", ifa.out_pvld, 1);
      chk("bp_next_mask", ifa.out_data[1024 +: 4], 4'h1);
      chk("bp_next_l0", a_lane(0), a_rep(8'h55));
      chk("bp_next_l1", a_lane(1), 0);
      chk("bp_next_end", ifa.out_end, 1);
      tick();
      chk("bp_drain", ifa.out_pvld, 0);

      // empty closing beat at cnt = 0
      a_beat(8'hff, 1'b0, 1'b1);
      a_idle();
      chk("empty_pvld", ifa.out_pvld, 1);
      chk("empty_mask", ifa.out_data[1024 +: 4], 0);
      chk("empty_l0", a_lane(0), 0);
      chk("empty_l3", a_lane(3), 0);
      chk("empty_end", ifa.out_end, 1);
      tick();

      // reset mid-packet
      a_beat(8'h71, 1'b1, 1'b0);
      a_beat(8'h72, 1'b1, 1'b0);
      a_idle();
      autosa_core_rstn = 1'b0;
      #1;
      chk("mrst_pvld", ifa.out_pvld, 0);
      chk("mrst_mask", ifa.out_data[1024 +: 4], 0);
      @(posedge autosa_core_clk);
      #1;
      autosa_core_rstn = 1'b1;
      tick();
      a_beat(8'h61, 1'b1, 1'b0);
      a_beat(8'h62, 1'b1, 1'b0);
      a_beat(8'h63, 1'b1, 1'b0);
      chk("mrst_pvld_early", ifa.out_pvld, 0);
      a_beat(8'h64, 1'b1, 1'b0);
      a_idle();
      chk("mrst_full_pvld", ifa.out_pvld, 1);
      chk("mrst_full_mask", ifa.out_data[1024 +: 4], 4'hf);
      chk("mrst_full_l0", a_lane(0), a_rep(8'h61));
      chk("mrst_full_l3", a_lane(3), a_rep(8'h64));
      chk("mrst_full_end", ifa.out_end, 0);
      chk("a_err", ifa.err_ovf, 0);
      tick();

      // unit B: 2 -> 3 atoms, overflow drops the 4th atom
      chk("b_rst_err", ifb.err_ovf, 0);
      b_beat(2'b11, 8'h02, 8'h01, 1'b0);
      b_beat(2'b11, 8'h04, 8'h03, 1'b0);
      b_idle();
      chk("ovf_pvld", ifb.out_pvld, 1);
      chk("ovf_mask", ifb.out_data[24 +: 3], 3'h7);
      chk("ovf_l0", b_lane(0), 8'h01);
      chk("ovf_l1", b_lane(1), 8'h02);
      chk("ovf_l2", b_lane(2), 8'h03);
      chk("ovf_end", ifb.out_end, 0);
      chk("ovf_err", ifb.err_ovf, ERR_EXP);
      tick();

      // next segment restarts at cnt = 0; upper input lane ignored for size 1
      b_beat(2'b01, 8'hee, 8'h05, 1'b1);
      b_idle();
      chk("seg_pvld", ifb.out_pvld, 1);
      chk("seg_mask", ifb.out_data[24 +: 3], 3'h1);
      chk("seg_l0", b_lane(0), 8'h05);
      chk("seg_l1", b_lane(1), 8'h00);
      chk("seg_l2", b_lane(2), 8'h00);
      chk("seg_end", ifb.out_end, 1);
      chk("seg_err_sticky", ifb.err_ovf, ERR_EXP);
      tick();

      // 1 + 2 atoms fill exactly
      b_beat(2'b01, 8'h99, 8'h0a, 1'b0);
      b_beat(2'b11, 8'h0c, 8'h0b, 1'b0);
      b_idle();
      chk("exact_pvld", ifb.out_pvld, 1);
      chk("exact_mask", ifb.out_data[24 +: 3], 3'h7);
      chk("exact_l0", b_lane(0), 8'h0a);
      chk("exact_l1", b_lane(1), 8'h0b);
      chk("exact_l2", b_lane(2), 8'h0c);
      chk("exact_err_sticky", ifb.err_ovf, ERR_EXP);
      tick();
      chk("exact_drain", ifb.out_pvld, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
